// File: rtl/fc_layer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fc_layer_ctrl_pkg
// Shared definitions for the fully-connected layer sequencer: the default
// layer geometry and bus widths, the derived pair/group counts for that
// geometry, the controller state encoding and a small counter-width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package fc_layer_ctrl_pkg;

  localparam int DEF_FC_INNEURON_ADDR_WIDTH = 9;
  localparam int DEF_OUTNEURON              = 10;
  localparam int DEF_INNEURON               = 576;
  localparam int DEF_PI                     = 16;
  localparam int DEF_PO                     = 1;
  localparam int DEF_MAC_LATENCY            = 3;
  localparam int DEF_W_ADDR_WIDTH           = 8;
  localparam int DEF_OUT_ADDR_WIDTH         = 4;

  // Each read fetches an even/odd word pair, so one group needs
  // INNEURON/(2*PI) reads; groups are OUTNEURON/PO.
  localparam int DEF_NPAIR = DEF_INNEURON / (2 * DEF_PI);
  localparam int DEF_NGRP  = DEF_OUTNEURON / DEF_PO;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } fc_state_e;

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_layer_ctrl_if.sv
// ----------------------------------------------------------------------------
// fc_layer_ctrl_if
// Bundles the layer-scheduler handshake (start/hold/busy/done) together with
// the read, weight, MAC and output-buffer strobes produced by the sequencer.
//   master : scheduler side, drives start/hold, observes everything else
//   slave  : the sequencer, samples start/hold, drives everything else
// ----------------------------------------------------------------------------
interface fc_layer_ctrl_if #(
  parameter int AW  = fc_layer_ctrl_pkg::DEF_FC_INNEURON_ADDR_WIDTH,
  parameter int WAW = fc_layer_ctrl_pkg::DEF_W_ADDR_WIDTH,
  parameter int OAW = fc_layer_ctrl_pkg::DEF_OUT_ADDR_WIDTH
) ();

  logic           start;
  logic           hold;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [AW-1:0]  addra;
  logic [AW-1:0]  addrb;
  logic [WAW-1:0] w_addr;
  logic           acc_en;
  logic           acc_clear;
  logic           out_we;
  logic [OAW-1:0] out_addr;

  modport master (
    output start, hold,
    input  busy, done, rd_en, addra, addrb, w_addr,
    input  acc_en, acc_clear, out_we, out_addr
  );

  modport slave (
    input  start, hold,
    output busy, done, rd_en, addra, addrb, w_addr,
    output acc_en, acc_clear, out_we, out_addr
  );

endinterface

// File: rtl/fc_layer_ctrl_lat_pipe.sv
// ----------------------------------------------------------------------------
// fc_lat_pipe
// Delays the read strobe and its first-of-group flag by the datapath latency
// so the MAC sees accumulate/clear exactly when the operands arrive.
//   clk, reset   : clock, asynchronous active-high reset
//   rd_en_i      : read issued this cycle
//   first_i      : this read is the first one of an output group
//   acc_en_o     : rd_en_i delayed by LATENCY cycles
//   acc_clear_o  : first_i delayed by LATENCY cycles
// ----------------------------------------------------------------------------
module fc_lat_pipe #(
  parameter int LATENCY = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic rd_en_i,
  input  logic first_i,
  output logic acc_en_o,
  output logic acc_clear_o
);

  logic [LATENCY-1:0] en_q;
  logic [LATENCY-1:0] first_q;

  // Plain shift register; it never stalls, so a hold upstream shows up as an
  // identical gap in acc_en LATENCY cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q    <= '0;
      first_q <= '0;
    end else begin
      en_q[0]    <= rd_en_i;
      first_q[0] <= first_i;
      for (int i = 1; i < LATENCY; i++) begin
        en_q[i]    <= en_q[i-1];
        first_q[i] <= first_q[i-1];
      end
    end
  end

  assign acc_en_o    = en_q[LATENCY-1];
  assign acc_clear_o = first_q[LATENCY-1];

endmodule

// File: rtl/fc_layer_ctrl.sv
// ----------------------------------------------------------------------------
// fc_layer_ctrl
// Sequencer for one fully-connected layer. After start it walks every output
// group: issues NPAIR paired input reads with matching weight addresses,
// drains the MAC pipeline, writes the finished neuron, and pulses done after
// the last group.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : fc_layer_ctrl_if.slave (start/hold in; busy, done, rd_en,
//            addra, addrb, w_addr, acc_en, acc_clear, out_we, out_addr out)
// ----------------------------------------------------------------------------
module fc_layer_ctrl
  import fc_layer_ctrl_pkg::*;
#(
  parameter int FC_INNEURON_ADDR_WIDTH = DEF_FC_INNEURON_ADDR_WIDTH,
  parameter int OUTNEURON              = DEF_OUTNEURON,
  parameter int INNEURON               = DEF_INNEURON,
  parameter int PI                     = DEF_PI,
  parameter int PO                     = DEF_PO,
  parameter int MAC_LATENCY            = DEF_MAC_LATENCY,
  parameter int W_ADDR_WIDTH           = DEF_W_ADDR_WIDTH,
  parameter int OUT_ADDR_WIDTH         = DEF_OUT_ADDR_WIDTH
) (
  input logic           clk,
  input logic           reset,
  fc_layer_ctrl_if.slave bus
);

  localparam int NPAIR = INNEURON / (2 * PI);
  localparam int NGRP  = OUTNEURON / PO;
  localparam int KW    = cnt_width(NPAIR);
  localparam int GW    = cnt_width(NGRP);
  localparam int LW    = cnt_width(MAC_LATENCY);
  localparam int AW    = FC_INNEURON_ADDR_WIDTH;

  fc_state_e                 state_q;
  logic [KW-1:0]             k_q;
  logic [GW-1:0]             g_q;
  logic [LW-1:0]             dcnt_q;
  logic [AW-1:0]             addra_q;
  logic [AW-1:0]             addrb_q;
  logic [W_ADDR_WIDTH-1:0]   w_addr_q;
  logic [OUT_ADDR_WIDTH-1:0] out_addr_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      out_we_q;

  logic rd_en;
  logic first_rd;
  logic last_pair;
  logic last_grp;

  // The addresses are registered ahead of time, so a read can go out in the
  // same cycle the scheduler drops hold; hold gates only the strobe.
  assign rd_en     = (state_q == RUN) && !bus.hold;
  assign first_rd  = rd_en && (k_q == '0);
  assign last_pair = (k_q == KW'(NPAIR - 1));
  assign last_grp  = (g_q == GW'(NGRP - 1));

  // Single controller process: state, pair/group/drain counters and every
  // registered output. Addresses always point at the next read to issue.
  // w_addr simply counts reads across groups, since g*NPAIR+k advances by
  // one per read; after the very last read it parks at 0 so it never shows
  // a value past the end of the weight ROM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      g_q        <= '0;
      dcnt_q     <= '0;
      addra_q    <= '0;
      addrb_q    <= '0;
      w_addr_q   <= '0;
      out_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_we_q   <= 1'b0;
    end else begin
      out_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            k_q      <= '0;
            g_q      <= '0;
            addra_q  <= '0;
            addrb_q  <= AW'(1);
            w_addr_q <= '0;
          end
        end
        RUN: begin
          if (!bus.hold) begin
            if (last_pair) begin
              k_q     <= '0;
              addra_q <= '0;
              addrb_q <= AW'(1);
              dcnt_q  <= '0;
              state_q <= DRAIN;
              w_addr_q <= last_grp ? '0 : w_addr_q + W_ADDR_WIDTH'(1);
            end else begin
              k_q      <= k_q + KW'(1);
              addra_q  <= addra_q + AW'(2);
              addrb_q  <= addrb_q + AW'(2);
              w_addr_q <= w_addr_q + W_ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (dcnt_q == LW'(MAC_LATENCY - 1)) begin
            state_q    <= WRITE;
            out_we_q   <= 1'b1;
            out_addr_q <= OUT_ADDR_WIDTH'(g_q);
          end else begin
            dcnt_q <= dcnt_q + LW'(1);
          end
        end
        WRITE: begin
          if (last_grp) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            g_q     <= g_q + GW'(1);
            state_q <= RUN;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fc_lat_pipe #(
    .LATENCY (MAC_LATENCY)
  ) u_lat_pipe (
    .clk         (clk),
    .reset       (reset),
    .rd_en_i     (rd_en),
    .first_i     (first_rd),
    .acc_en_o    (bus.acc_en),
    .acc_clear_o (bus.acc_clear)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en;
  assign bus.addra    = addra_q;
  assign bus.addrb    = addrb_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.out_we   = out_we_q;
  assign bus.out_addr = out_addr_q;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fc_layer_ctrl
// Drives two sequencers side by side (MAC_LATENCY 3 and 1) from the same hold
// pattern. Expected traces come from a schedule model: reads fill the
// non-hold RUN cycles, each read produces acc_en LAT cycles later, and the
// write and done follow at fixed offsets from the last read.
// ----------------------------------------------------------------------------
module tb_fc_layer_ctrl;
  import fc_layer_ctrl_pkg::*;

  localparam int INNEURON  = 576;
  localparam int PI        = 16;
  localparam int OUTNEURON = 10;
  localparam int PO        = 1;
  localparam int NPAIR     = INNEURON / (2 * PI);
  localparam int NGRP      = OUTNEURON / PO;
  localparam int LAT_A     = 3;
  localparam int LAT_B     = 1;
  localparam int MAXC      = 1200;

  typedef struct {int rd, acc, clr, we, done, busy, run, a, b, w, oa;} rec_t;
  typedef struct {int run, dut, cyc, rd, acc, clr, we, done, busy, a, b, w, oa;} vec_t;

  logic clk = 1'b0;
  logic reset;
  int   nAssert;
  int   nFail;
  int   holdVec [MAXC];
  rec_t expv [2][MAXC];
  rec_t actv [2][MAXC];
  vec_t vecs [$];

  always #5 clk = ~clk;

  fc_layer_ctrl_if #(.AW(9), .WAW(8), .OAW(4)) busA ();
  fc_layer_ctrl_if #(.AW(9), .WAW(8), .OAW(4)) busB ();

  fc_layer_ctrl #(
    .FC_INNEURON_ADDR_WIDTH(9), .OUTNEURON(OUTNEURON), .INNEURON(INNEURON), .PI(PI),
    .PO(PO), .MAC_LATENCY(LAT_A), .W_ADDR_WIDTH(8), .OUT_ADDR_WIDTH(4)
  ) dutA (.clk(clk), .reset(reset), .bus(busA));

  fc_layer_ctrl #(
    .FC_INNEURON_ADDR_WIDTH(9), .OUTNEURON(OUTNEURON), .INNEURON(INNEURON), .PI(PI),
    .PO(PO), .MAC_LATENCY(LAT_B), .W_ADDR_WIDTH(8), .OUT_ADDR_WIDTH(4)
  ) dutB (.clk(clk), .reset(reset), .bus(busB));

  // Geometry sanity: the pair structure needs INNEURON divisible by 2*PI.
  initial begin
    if ((INNEURON % (2 * PI)) != 0 || NPAIR != DEF_NPAIR || NGRP != DEF_NGRP) begin
      $display("[TB] FAIL elab_geometry: INNEURON=%0d not a multiple of 2*PI=%0d", INNEURON, 2 * PI);
      $fatal(1, "[TB] bad geometry");
    end
  end

  task automatic chk(input string nm, input int d, input int c, input int act, input int exp);
    nAssert++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %0d, expected %0d", nm, d, c, act, exp);
    end
  endtask

  function automatic rec_t sampleDut(input int d);
    rec_t r;
    if (d == 0)
      r = '{int'(busA.rd_en), int'(busA.acc_en), int'(busA.acc_clear), int'(busA.out_we),
            int'(busA.done), int'(busA.busy), 0, int'(busA.addra), int'(busA.addrb),
            int'(busA.w_addr), int'(busA.out_addr)};
    else
      r = '{int'(busB.rd_en), int'(busB.acc_en), int'(busB.acc_clear), int'(busB.out_we),
            int'(busB.done), int'(busB.busy), 0, int'(busB.addra), int'(busB.addrb),
            int'(busB.w_addr), int'(busB.out_addr)};
    return r;
  endfunction

  // Schedule model: walk groups and pairs, skipping hold cycles while reading.
  task automatic buildModel(input int d, input int lat, output int doneC);
    int t;
    for (int c = 0; c < MAXC; c++) expv[d][c] = '{default: 0};
    t = 1;
    for (int g = 0; g < NGRP; g++) begin
      for (int p = 0; p < NPAIR; p++) begin
        while (holdVec[t] != 0) begin
          expv[d][t].busy = 1; expv[d][t].run = 1;
          expv[d][t].a = 2 * p; expv[d][t].b = 2 * p + 1; expv[d][t].w = g * NPAIR + p;
          t++;
        end
        expv[d][t].busy = 1; expv[d][t].run = 1; expv[d][t].rd = 1;
        expv[d][t].a = 2 * p; expv[d][t].b = 2 * p + 1; expv[d][t].w = g * NPAIR + p;
        expv[d][t + lat].acc = 1;
        expv[d][t + lat].clr = (p == 0) ? 1 : 0;
        t++;
      end
      for (int i = 0; i <= lat; i++) expv[d][t + i].busy = 1;
      expv[d][t + lat].we = 1;
      expv[d][t + lat].oa = g;
      t = t + lat + 1;
    end
    expv[d][t].busy = 1;
    expv[d][t].done = 1;
    doneC = t;
  endtask

  task automatic checkOutput(input int d, input int c);
    rec_t e;
    rec_t r;
    e = expv[d][c];
    r = actv[d][c];
    chk("rd_en", d, c, r.rd, e.rd);
    chk("acc_en", d, c, r.acc, e.acc);
    chk("acc_clear", d, c, r.clr, e.clr);
    chk("out_we", d, c, r.we, e.we);
    chk("done", d, c, r.done, e.done);
    chk("busy", d, c, r.busy, e.busy);
    if (e.run != 0) begin
      chk("addra", d, c, r.a, e.a);
      chk("addrb", d, c, r.b, e.b);
      chk("w_addr", d, c, r.w, e.w);
    end
    if (e.we != 0) chk("out_addr", d, c, r.oa, e.oa);
  endtask

  task automatic checkZero(input string nm);
    rec_t r;
    for (int d = 0; d < 2; d++) begin
      r = sampleDut(d);
      chk({nm, "_flags"}, d, 0, r.rd + r.acc + r.clr + r.we + r.done + r.busy, 0);
      chk({nm, "_addra"}, d, 0, r.a, 0);
      chk({nm, "_addrb"}, d, 0, r.b, 0);
      chk({nm, "_w_addr"}, d, 0, r.w, 0);
      chk({nm, "_out_addr"}, d, 0, r.oa, 0);
    end
  endtask

  // mode 0: start only to launch; 1: random start noise while busy;
  // 2: start pulsed in the middle of RUN and in the DONE cycle.
  task automatic applyStimulus(input int c, input int mode, input int dA, input int dB);
    busA.hold = holdVec[c][0];
    busB.hold = holdVec[c][0];
    busA.start = 1'b0;
    busB.start = 1'b0;
    if (mode == 1) begin
      busA.start = (c <= dA) && ($urandom_range(0, 7) == 0);
      busB.start = (c <= dB) && ($urandom_range(0, 7) == 0);
    end else if (mode == 2) begin
      busA.start = (c == 10) || (c == dA);
      busB.start = (c == 10) || (c == dB);
    end
  endtask

  task automatic runLayer(input int mode, input int abortAt);
    int dA, dB, endC;
    buildModel(0, LAT_A, dA);
    buildModel(1, LAT_B, dB);
    endC = (abortAt > 0) ? abortAt : (((dA > dB) ? dA : dB) + 1);
    @(negedge clk);
    busA.start = 1'b1; busB.start = 1'b1;
    busA.hold = 1'b0;  busB.hold = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= endC; c++) begin
      #1 applyStimulus(c, mode, dA, dB);
      #1;
      for (int d = 0; d < 2; d++) begin
        actv[d][c] = sampleDut(d);
        checkOutput(d, c);
      end
      if (c == abortAt) begin
        #1 reset = 1'b1;
        #1 checkZero("abort");
        break;
      end
      @(posedge clk);
    end
    if (abortAt > 0) begin
      @(negedge clk);
      reset = 1'b0;
      busA.hold = 1'b0; busB.hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("post_abort_done", 0, i, int'(busA.done), 0);
        chk("post_abort_busy", 1, i, int'(busB.busy), 0);
      end
    end
  endtask

  task automatic checkTable(input int runId);
    rec_t r;
    int   fa, fe;
    foreach (vecs[i]) begin
      if (vecs[i].run == runId) begin
        r  = actv[vecs[i].dut][vecs[i].cyc];
        fa = r.rd * 32 + r.acc * 16 + r.clr * 8 + r.we * 4 + r.done * 2 + r.busy;
        fe = vecs[i].rd * 32 + vecs[i].acc * 16 + vecs[i].clr * 8 + vecs[i].we * 4
           + vecs[i].done * 2 + vecs[i].busy;
        chk("vec_flags", vecs[i].dut, vecs[i].cyc, fa, fe);
        if (vecs[i].a >= 0)  chk("vec_addra", vecs[i].dut, vecs[i].cyc, r.a, vecs[i].a);
        if (vecs[i].b >= 0)  chk("vec_addrb", vecs[i].dut, vecs[i].cyc, r.b, vecs[i].b);
        if (vecs[i].w >= 0)  chk("vec_w_addr", vecs[i].dut, vecs[i].cyc, r.w, vecs[i].w);
        if (vecs[i].oa >= 0) chk("vec_out_addr", vecs[i].dut, vecs[i].cyc, r.oa, vecs[i].oa);
      end
    end
  endtask

  task automatic setHold(input int pct);
    for (int c = 0; c < MAXC; c++)
      holdVec[c] = (pct > 0 && c > 0 && c < 600 && $urandom_range(0, 99) < pct) ? 1 : 0;
  endtask

  initial begin
    nAssert = 0;
    nFail   = 0;
    reset   = 1'b1;
    busA.start = 1'b0; busA.hold = 1'b0;
    busB.start = 1'b0; busB.hold = 1'b0;

    // run, dut, cycle, rd, acc, clr, we, done, busy, addra, addrb, w_addr, out_addr
    vecs.push_back('{0, 0,   1, 1, 0, 0, 0, 0, 1,  0,  1,   0, -1});
    vecs.push_back('{0, 0,   2, 1, 0, 0, 0, 0, 1,  2,  3,   1, -1});
    vecs.push_back('{0, 0,   4, 1, 1, 1, 0, 0, 1,  6,  7,   3, -1});
    vecs.push_back('{0, 0,   5, 1, 1, 0, 0, 0, 1,  8,  9,   4, -1});
    vecs.push_back('{0, 0,  18, 1, 1, 0, 0, 0, 1, 34, 35,  17, -1});
    vecs.push_back('{0, 0,  19, 0, 1, 0, 0, 0, 1, -1, -1,  -1, -1});
    vecs.push_back('{0, 0,  21, 0, 1, 0, 0, 0, 1, -1, -1,  -1, -1});
    vecs.push_back('{0, 0,  22, 0, 0, 0, 1, 0, 1, -1, -1,  -1,  0});
    vecs.push_back('{0, 0,  23, 1, 0, 0, 0, 0, 1,  0,  1,  18, -1});
    vecs.push_back('{0, 0,  26, 1, 1, 1, 0, 0, 1,  6,  7,  21, -1});
    vecs.push_back('{0, 0, 216, 1, 1, 0, 0, 0, 1, 34, 35, 179, -1});
    vecs.push_back('{0, 0, 220, 0, 0, 0, 1, 0, 1, -1, -1,  -1,  9});
    vecs.push_back('{0, 0, 221, 0, 0, 0, 0, 1, 1, -1, -1,  -1, -1});
    vecs.push_back('{0, 0, 222, 0, 0, 0, 0, 0, 0, -1, -1,  -1, -1});
    vecs.push_back('{0, 1,   1, 1, 0, 0, 0, 0, 1,  0,  1,   0, -1});
    vecs.push_back('{0, 1,   2, 1, 1, 1, 0, 0, 1,  2,  3,   1, -1});
    vecs.push_back('{0, 1,   3, 1, 1, 0, 0, 0, 1,  4,  5,   2, -1});
    vecs.push_back('{0, 1,  19, 0, 1, 0, 0, 0, 1, -1, -1,  -1, -1});
    vecs.push_back('{0, 1,  20, 0, 0, 0, 1, 0, 1, -1, -1,  -1,  0});
    vecs.push_back('{0, 1,  22, 1, 1, 1, 0, 0, 1,  2,  3,  19, -1});
    vecs.push_back('{0, 1, 200, 0, 0, 0, 1, 0, 1, -1, -1,  -1,  9});
    vecs.push_back('{0, 1, 201, 0, 0, 0, 0, 1, 1, -1, -1,  -1, -1});
    vecs.push_back('{0, 1, 202, 0, 0, 0, 0, 0, 0, -1, -1,  -1, -1});
    vecs.push_back('{1, 0,  51, 1, 1, 0, 0, 0, 1, 12, 13,  42, -1});
    vecs.push_back('{1, 0,  52, 0, 1, 0, 0, 0, 1, 14, 15,  43, -1});
    vecs.push_back('{1, 0,  55, 0, 0, 0, 0, 0, 1, 14, 15,  43, -1});
    vecs.push_back('{1, 0,  56, 0, 0, 0, 0, 0, 1, 14, 15,  43, -1});
    vecs.push_back('{1, 0,  57, 1, 0, 0, 0, 0, 1, 14, 15,  43, -1});
    vecs.push_back('{1, 0,  59, 1, 0, 0, 0, 0, 1, 18, 19,  45, -1});
    vecs.push_back('{1, 0,  60, 1, 1, 0, 0, 0, 1, 20, 21,  46, -1});
    vecs.push_back('{1, 0, 226, 0, 0, 0, 0, 1, 1, -1, -1,  -1, -1});
    vecs.push_back('{1, 0, 227, 0, 0, 0, 0, 0, 0, -1, -1,  -1, -1});
    vecs.push_back('{1, 1,  52, 0, 1, 0, 0, 0, 1, 22, 23,  47, -1});
    vecs.push_back('{1, 1,  53, 0, 0, 0, 0, 0, 1, 22, 23,  47, -1});
    vecs.push_back('{1, 1,  57, 1, 0, 0, 0, 0, 1, 22, 23,  47, -1});
    vecs.push_back('{1, 1, 206, 0, 0, 0, 0, 1, 1, -1, -1,  -1, -1});
    vecs.push_back('{1, 1, 207, 0, 0, 0, 0, 0, 0, -1, -1,  -1, -1});

    #2 checkZero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    setHold(0);
    runLayer(0, 0);
    checkTable(0);

    setHold(0);
    for (int c = 52; c <= 56; c++) holdVec[c] = 1;
    runLayer(0, 0);
    checkTable(1);

    setHold(0);
    runLayer(2, 0);

    setHold(0);
    runLayer(0, 120);

    setHold(0);
    runLayer(0, 0);

    for (int r = 0; r < 3; r++) begin
      setHold(20);
      runLayer(1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
